gpio_host: RTL and testbench

GPIO_HOST -- requirements
Module: gpio_host

---
 rtl/gpio_host_pkg.sv | 12 +
 rtl/gpio_host_sync_fifo.sv | 58 +++++
 rtl/gpio_host.sv | 133 +++++++++++++
 tb/tb_gpio_host.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_host_pkg.sv
// Shared types and default constants for the GPIO host bridge.
package gpio_host_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    localparam int DEFAULT_FIFO_DEPTH  = 4;
    localparam int DEFAULT_HOLD_CYCLES = 8;

endpackage

// File: rtl/gpio_host_sync_fifo.sv
// Single-clock FIFO with occupancy count; a push into a full FIFO is accepted
// only when a pop happens on the same edge.
module sync_fifo #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign rdata   = mem[rd_ptr];

    // Storage carries no reset; occupancy is tracked solely by count/pointers.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/gpio_host.sv
// Host-side GPIO bridge: queues words onto gpio_in with a minimum hold time and
// turns every change on gpio_out into an event in a drop-on-full FIFO.
module gpio_host
    import gpio_host_pkg::*;
#(
    parameter int FIFO_DEPTH  = DEFAULT_FIFO_DEPTH,
    parameter int HOLD_CYCLES = DEFAULT_HOLD_CYCLES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] gpio_in,
    input  logic [31:0] gpio_out,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        overflow,
    input  logic        overflow_clr,
    output state_e      dbg_state
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);

    state_e         state, state_nx;
    logic [CW-1:0]  hold_cnt, hold_cnt_nx;
    logic [31:0]    gpio_in_nx;
    logic [31:0]    prev_out;

    logic [31:0]    in_rdata;
    logic           in_full, in_empty, in_pop;
    logic [AW:0]    in_count;
    logic           ev_full, ev_empty, ev_pop, change, drop;
    logic [AW:0]    ev_count;
    logic           unused_fifo_status;

    assign unused_fifo_status = ^{in_full, ev_count};
    assign dbg_state          = state;

    // Handshakes: a word moves on in_valid&&in_ready, an event on
    // out_valid&&out_ready, both sampled at the rising edge of clk.
    assign in_ready = (in_count < (AW+1)'(FIFO_DEPTH));

    sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_in_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_valid && in_ready),
        .pop   (in_pop),
        .wdata (in_data),
        .rdata (in_rdata),
        .full  (in_full),
        .empty (in_empty),
        .count (in_count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            hold_cnt <= '0;
            gpio_in  <= '0;
        end else begin
            state    <= state_nx;
            hold_cnt <= hold_cnt_nx;
            gpio_in  <= gpio_in_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        hold_cnt_nx = hold_cnt;
        gpio_in_nx  = gpio_in;
        in_pop      = 1'b0;
        case (state)
            IDLE: begin
                if (!in_empty) begin
                    in_pop      = 1'b1;
                    gpio_in_nx  = in_rdata;
                    hold_cnt_nx = HOLD_LOAD;
                    state_nx    = HOLD;
                end
            end
            HOLD: begin
                if (hold_cnt != '0) begin
                    hold_cnt_nx = hold_cnt - 1'b1;
                end else if (!in_empty) begin
                    in_pop      = 1'b1;
                    gpio_in_nx  = in_rdata;
                    hold_cnt_nx = HOLD_LOAD;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Change detection against the previous edge's sample; reset value 0 makes
    // the first nonzero gpio_out after reset an event.
    assign change    = (gpio_out != prev_out);
    assign out_valid = !ev_empty;
    assign ev_pop    = out_valid && out_ready;
    assign drop      = change && ev_full && !ev_pop;

    sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_ev_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (change),
        .pop   (ev_pop),
        .wdata (gpio_out),
        .rdata (out_data),
        .full  (ev_full),
        .empty (ev_empty),
        .count (ev_count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_out <= '0;
            overflow <= 1'b0;
        end else begin
            prev_out <= gpio_out;
            if (drop) begin
                overflow <= 1'b1;
            end else if (overflow_clr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_gpio_host.sv
// Directed bench for gpio_host: expected gpio_in words and events are queued at
// issue time and a negedge monitor pops and compares them as the DUT shows them.
module tb_gpio_host;
    import gpio_host_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] gpio_in;
    logic [31:0] gpio_out = '0;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        overflow;
    logic        overflow_clr = 1'b0;
    state_e      dbg_state;

    logic [31:0] gin_exp_q[$];
    logic [31:0] ev_exp_q[$];
    logic [31:0] last_gin = '0;
    int          checks = 0;
    int          errors = 0;
    int          ev_seen = 0;

    gpio_host #(.FIFO_DEPTH(4), .HOLD_CYCLES(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .gpio_in      (gpio_in),
        .gpio_out     (gpio_out),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .overflow     (overflow),
        .overflow_clr (overflow_clr),
        .dbg_state    (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input logic [31:0] act);
        checks++;
        errors++;
        $display("FAIL %s: got %h expected nothing", name, act);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // driver: present one word until accepted (bounded)
    task automatic push_word(input logic [31:0] d, input bit expect_it);
        bit acc;
        int n;
        acc = 1'b0;
        n = 0;
        in_data = d;
        in_valid = 1'b1;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = in_ready;
            step();
            n++;
        end
        in_valid = 1'b0;
        if (!acc) fail("push_timeout", d);
        else if (expect_it) gin_exp_q.push_back(d);
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((gin_exp_q.size() != 0 || ev_exp_q.size() != 0) && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) fail("drain_timeout", gin_exp_q.size() + ev_exp_q.size());
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (!rst) begin
            last_gin = '0;
        end else begin
            if (gpio_in !== last_gin) begin
                if (gin_exp_q.size() == 0) fail("gpio_in_unexpected", gpio_in);
                else check("gpio_in_seq", gpio_in, gin_exp_q.pop_front());
                last_gin = gpio_in;
            end
            if (out_valid && out_ready) begin
                ev_seen++;
                if (ev_exp_q.size() == 0) fail("event_unexpected", out_data);
                else check("event_seq", out_data, ev_exp_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt11, cnt22, idx, acc_before_drop, seen0;
        bit seen_drop;

        #1 rst = 1'b0;
        #1;
        check("rst_gpio_in", gpio_in, 32'h0);
        check("rst_in_ready", {31'b0, in_ready}, 32'h1);
        check("rst_out_valid", {31'b0, out_valid}, 32'h0);
        check("rst_overflow", {31'b0, overflow}, 32'h0);
        check("rst_state", {31'b0, dbg_state}, {31'b0, IDLE});
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        step();

        // two back-to-back words from IDLE: 2-cycle latency, 8-cycle holds
        in_valid = 1'b1;
        in_data = 32'h11;
        gin_exp_q.push_back(32'h11);
        step();
        in_data = 32'h22;
        gin_exp_q.push_back(32'h22);
        @(negedge clk);
        check("latency_before_edge2", gpio_in, 32'h0);
        step();
        in_valid = 1'b0;
        cnt11 = 0;
        cnt22 = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k == 0) check("gpio_in_at_edge2", gpio_in, 32'h11);
            if (gpio_in == 32'h11) cnt11++;
            if (gpio_in == 32'h22) cnt22++;
        end
        check("hold_0x11_cycles", cnt11, 8);
        check("hold_0x22_retained", cnt22, 12);
        check("idle_after_holds", {31'b0, dbg_state}, {31'b0, IDLE});
        step();

        // backpressure: one word enters HOLD, then stream 6 more with no drain
        push_word(32'h100, 1'b1);
        idx = 0;
        acc_before_drop = 0;
        seen_drop = 1'b0;
        seen0 = 0;
        in_valid = 1'b1;
        while (idx < 6 && seen0 < 300) begin
            in_data = 32'h101 + idx;
            @(negedge clk);
            if (in_ready) begin
                gin_exp_q.push_back(in_data);
                idx++;
                if (!seen_drop) acc_before_drop++;
            end else begin
                seen_drop = 1'b1;
            end
            step();
            seen0++;
        end
        in_valid = 1'b0;
        check("accepted_before_full", acc_before_drop, 4);
        check("stream_all_accepted", idx, 6);
        wait_drain(200);
        repeat (20) step();
        check("gpio_in_retained", gpio_in, 32'h106);

        // one change held for 20 cycles -> exactly one event
        out_ready = 1'b1;
        seen0 = ev_seen;
        gpio_out = 32'hA5A5A5A5;
        ev_exp_q.push_back(32'hA5A5A5A5);
        @(negedge clk);
        check("out_valid_before_detect", {31'b0, out_valid}, 32'h0);
        step();
        @(negedge clk);
        check("out_valid_after_detect", {31'b0, out_valid}, 32'h1);
        repeat (20) step();
        check("single_event_count", ev_seen - seen0, 1);

        // overflow: 5 changes into a depth-4 FIFO with no drain
        out_ready = 1'b0;
        for (int v = 1; v <= 5; v++) begin
            gpio_out = v;
            if (v <= 4) ev_exp_q.push_back(v);
            step();
        end
        @(negedge clk);
        check("overflow_set", {31'b0, overflow}, 32'h1);
        check("head_after_overflow", out_data, 32'h1);
        gpio_out = 32'h7;
        overflow_clr = 1'b1;
        step();
        overflow_clr = 1'b0;
        @(negedge clk);
        check("drop_beats_clear", {31'b0, overflow}, 32'h1);
        overflow_clr = 1'b1;
        step();
        overflow_clr = 1'b0;
        @(negedge clk);
        check("overflow_cleared", {31'b0, overflow}, 32'h0);

        // full FIFO with simultaneous pop and new change -> accepted
        out_ready = 1'b1;
        gpio_out = 32'h6;
        ev_exp_q.push_back(32'h6);
        step();
        @(negedge clk);
        check("no_drop_with_pop", {31'b0, overflow}, 32'h0);
        wait_drain(50);
        check("overflow_after_drain", {31'b0, overflow}, 32'h0);

        // reset mid-HOLD with 2 words and 3 events pending
        out_ready = 1'b0;
        gpio_out = 32'h31;
        push_word(32'h200, 1'b1);
        gpio_out = 32'h32;
        push_word(32'h201, 1'b0);
        gpio_out = 32'h33;
        push_word(32'h202, 1'b0);
        @(negedge clk);
        check("gpio_in_before_reset", gpio_in, 32'h200);
        check("state_before_reset", {31'b0, dbg_state}, {31'b0, HOLD});
        step();
        rst = 1'b0;
        gin_exp_q.delete();
        ev_exp_q.delete();
        gpio_out = 32'h0;
        #1;
        check("async_rst_gpio_in", gpio_in, 32'h0);
        check("async_rst_in_ready", {31'b0, in_ready}, 32'h1);
        check("async_rst_out_valid", {31'b0, out_valid}, 32'h0);
        step();
        rst = 1'b1;
        out_ready = 1'b1;
        repeat (30) step();
        check("no_replay_gpio_in", gpio_in, 32'h0);
        check("no_replay_out_valid", {31'b0, out_valid}, 32'h0);

        check("gin_queue_empty", gin_exp_q.size(), 0);
        check("ev_queue_empty", ev_exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
